// File: rtl/alu_control_mdu.sv
// alu_control_mdu: EX-stage ALU control with an integrated iterative
// unsigned multiplier (MULTU) and HI/LO read-out (MFHI/MFLO).
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         synchronous, active-high reset
//   ALU_op      main-control op class
//   Funct_ctrl  instruction funct field
//   valid       an instruction occupies EX this cycle
//   src_a       rs operand (multiplicand)
//   src_b       rt operand (multiplier)
//   Funct       ALU function code
//   mdu_sel     writeback takes mdu_rd instead of the ALU result
//   mdu_rd      HI (MFHI) or LO (MFLO) data, 0 otherwise
//   busy        multiply in progress
//   stall       freeze IF/ID/EX this cycle
//
// BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH.
module alu_control_mdu #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALU_op,
  input  logic [5:0]       Funct_ctrl,
  input  logic             valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [5:0]       Funct,
  output logic             mdu_sel,
  output logic [WIDTH-1:0] mdu_rd,
  output logic             busy,
  output logic             stall
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = WIDTH + BITS_PER_CYCLE;      // partial-sum width
  localparam int AW   = 2 * WIDTH + BITS_PER_CYCLE;  // accumulator width
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_MFHI  = 6'b010000;
  localparam logic [5:0] FC_MFLO  = 6'b010010;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, hi, lo;
  logic [AW-1:0]    acc, acc_next;
  logic [PW-1:0]    partial, upper_sum;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             is_multu, is_mfhi, is_mflo;

  // Funct decode, independent of valid and multiplier state.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    Funct = 6'b000000;
    case (ALU_op)
      2'b00: Funct = 6'b001001;
      2'b01: Funct = 6'b001010;
      2'b11: Funct = 6'b100101;
      default: begin
        case (Funct_ctrl)
          6'b100001: Funct = 6'b001001;
          6'b100011: Funct = 6'b001010;
          6'b000000: Funct = 6'b100001;
          6'b000010: Funct = 6'b100010;
          6'b100101: Funct = 6'b100101;
          default:   Funct = 6'b000000;  // MULTU/MFHI/MFLO leave the ALU idle
        endcase
      end
    endcase
  end

  assign is_multu = valid && (ALU_op == 2'b10) && (Funct_ctrl == FC_MULTU);
  assign is_mfhi  = valid && (ALU_op == 2'b10) && (Funct_ctrl == FC_MFHI);
  assign is_mflo  = valid && (ALU_op == 2'b10) && (Funct_ctrl == FC_MFLO);

  // One iteration: add multiplicand x low multiplier digit into the upper
  // accumulator, then shift the whole accumulator right by one digit. The
  // upper slice is one digit wider than WIDTH so the add never overflows.
  always_comb begin
    partial   = PW'(mcand) * PW'(mplier[BITS_PER_CYCLE-1:0]);
    upper_sum = acc[AW-1:WIDTH] + partial;
    acc_next  = {upper_sum, acc[WIDTH-1:0]} >> BITS_PER_CYCLE;
  end

  assign done = (state == BUSY) && (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_multu) state_next = BUSY;
      BUSY:    if (done)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: HI/LO are architecturally visible and must read 0 after reset
      // (including a reset that aborts a multiply), so they are reset too.
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (is_multu) begin
          mcand  <= src_a;
          mplier <= src_b;
          acc    <= '0;
          cnt    <= '0;
        end
      end else begin
        acc    <= acc_next;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt    <= cnt + CW'(1);
        // HI/LO change only on completion, so reads during BUSY see the
        // previous product and never a partial one.
        if (done) begin
          hi <= acc_next[2*WIDTH-1:WIDTH];
          lo <= acc_next[WIDTH-1:0];
        end
      end
    end
  end

  assign busy    = (state == BUSY);
  assign stall   = busy && (is_multu || is_mfhi || is_mflo);
  assign mdu_sel = is_mfhi || is_mflo;
  assign mdu_rd  = is_mfhi ? hi : (is_mflo ? lo : '0);

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: table-driven decode sweep plus
// hand-written multiply sequences, with a product scoreboard queue.
module tb_alu_control_mdu;

  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_MFHI  = 6'b010000;
  localparam logic [5:0] FC_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ALU_op;
  logic [5:0]  Funct_ctrl;
  logic        valid, valid4;
  logic [31:0] src_a, src_b;

  logic [5:0]  Funct, Funct4;
  logic        mdu_sel, busy, stall;
  logic        mdu_sel4, busy4, stall4;
  logic [31:0] mdu_rd, mdu_rd4;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  alu_control_mdu dut (
    .clk(clk), .rst(rst), .ALU_op(ALU_op), .Funct_ctrl(Funct_ctrl),
    .valid(valid), .src_a(src_a), .src_b(src_b), .Funct(Funct),
    .mdu_sel(mdu_sel), .mdu_rd(mdu_rd), .busy(busy), .stall(stall)
  );

  alu_control_mdu #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .ALU_op(ALU_op), .Funct_ctrl(Funct_ctrl),
    .valid(valid4), .src_a(src_a), .src_b(src_b), .Funct(Funct4),
    .mdu_sel(mdu_sel4), .mdu_rd(mdu_rd4), .busy(busy4), .stall(stall4)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] fc;
    logic [5:0] exp_funct;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fc, input logic v,
                       input logic [31:0] a, input logic [31:0] b);
    ALU_op     = op;
    Funct_ctrl = fc;
    valid      = v;
    src_a      = a;
    src_b      = b;
  endtask

  task automatic issue_multu(input logic [31:0] a, input logic [31:0] b);
    drive(2'b10, FC_MULTU, 1'b1, a, b);
    exp_q.push_back(64'(a) * 64'(b));
  endtask

  task automatic pop_model();
    logic [63:0] p;
    if (exp_q.size() > 0) begin
      p   = exp_q.pop_front();
      mhi = p[63:32];
      mlo = p[31:0];
    end
  endtask

  // Counts busy cycles until busy drops (bounded); ends at a negedge with busy low.
  task automatic mul_wait(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      cyc();
    end
    pop_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    vecs[0]  = '{2'b00, 6'($urandom), 6'b001001};
    vecs[1]  = '{2'b01, 6'($urandom), 6'b001010};
    vecs[2]  = '{2'b11, 6'($urandom), 6'b100101};
    vecs[3]  = '{2'b10, 6'b100001,    6'b001001};
    vecs[4]  = '{2'b10, 6'b100011,    6'b001010};
    vecs[5]  = '{2'b10, 6'b000000,    6'b100001};
    vecs[6]  = '{2'b10, 6'b000010,    6'b100010};
    vecs[7]  = '{2'b10, 6'b100101,    6'b100101};
    vecs[8]  = '{2'b10, 6'b111111,    6'b000000};
    vecs[9]  = '{2'b10, FC_MULTU,     6'b000000};
    vecs[10] = '{2'b10, FC_MFHI,      6'b000000};
    vecs[11] = '{2'b10, FC_MFLO,      6'b000000};

    // Reset
    rst = 1'b1;
    valid4 = 1'b0;
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    check("reset_mdu_sel", mdu_sel, 0);
    check("reset_mdu_rd", mdu_rd, 0);
    check("reset_busy4", busy4, 0);

    // Decode sweep with valid low: no start, no stall, no mdu select
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive(vecs[i].op, vecs[i].fc, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      check($sformatf("decode_%0d", i), Funct, vecs[i].exp_funct);
      check($sformatf("decode4_%0d", i), Funct4, vecs[i].exp_funct);
      if (i >= 9) begin
        check($sformatf("vlow_sel_%0d", i), mdu_sel, 0);
        check($sformatf("vlow_stall_%0d", i), stall, 0);
      end
    end
    cyc();
    @(negedge clk);
    check("vlow_no_start", busy, 0);

    // MULTU 0xFFFFFFFF x 0xFFFFFFFF
    cyc();
    issue_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    mul_wait(n);
    check("max_busy_cycles", n, 32);
    cyc();
    drive(2'b10, FC_MFHI, 1'b1, '0, '0);
    @(negedge clk);
    check("max_mfhi", mdu_rd, mhi);
    check("max_mfhi_sel", mdu_sel, 1);
    check("max_mfhi_stall", stall, 0);
    cyc();
    drive(2'b10, FC_MFLO, 1'b1, '0, '0);
    @(negedge clk);
    check("max_mflo", mdu_rd, mlo);

    // MULTU 7x6, independent ADD, then dependent MFLO
    cyc();
    issue_multu(32'd7, 32'd6);
    cyc();
    drive(2'b00, 6'b100000, 1'b1, 32'd1, 32'd2);
    @(negedge clk);
    check("add_busy", busy, 1);
    check("add_stall", stall, 0);
    check("add_funct", Funct, 6'b001001);
    cyc();
    drive(2'b10, FC_MFLO, 1'b1, '0, '0);
    @(negedge clk);
    check("mflo_stalled_sel", mdu_sel, 1);
    check("mflo_stalled_old_lo", mdu_rd, mlo);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!stall) break;
      n++;
      cyc();
      @(negedge clk);
    end
    pop_model();
    check("mflo_stall_cycles", n, 31);
    check("mflo_result", mdu_rd, mlo);
    check("mflo_result_42", mdu_rd, 32'd42);
    check("mflo_busy_done", busy, 0);

    // BITS_PER_CYCLE=4 instance
    cyc();
    drive(2'b10, FC_MULTU, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    valid4 = 1'b1;
    cyc();
    valid4 = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy4) break;
      n++;
      cyc();
    end
    check("bpc4_busy_cycles", n, 8);
    cyc();
    drive(2'b10, FC_MFHI, 1'b0, '0, '0);
    valid4 = 1'b1;
    @(negedge clk);
    check("bpc4_hi", mdu_rd4, 32'h0B00_EA4E);
    check("bpc4_sel", mdu_sel4, 1);
    cyc();
    Funct_ctrl = FC_MFLO;
    @(negedge clk);
    check("bpc4_lo", mdu_rd4, 32'h242D_2080);
    cyc();
    valid4 = 1'b0;

    // Reset in the middle of a multiply
    issue_multu(32'h89AB_CDEF, 32'hFEDC_BA98);
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    mul_wait(n);
    cyc();
    issue_multu(32'h0000_1234, 32'h0000_5678);
    void'(exp_q.pop_back());  // this one is aborted and never completes
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    repeat (9) cyc();
    @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mhi = '0;
    mlo = '0;
    drive(2'b10, FC_MFHI, 1'b1, '0, '0);
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mfhi", mdu_rd, mhi);
    check("rst_mid_stall", stall, 0);
    cyc();
    drive(2'b10, FC_MFLO, 1'b1, '0, '0);
    @(negedge clk);
    check("rst_mid_mflo", mdu_rd, mlo);

    // Back-to-back MULTU
    cyc();
    issue_multu(32'hDEAD_BEEF, 32'h0000_1234);
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    mul_wait(n);
    cyc();
    issue_multu(32'hCAFE_F00D, 32'h8765_4321);
    cyc();
    drive(2'b10, FC_MFHI, 1'b1, '0, '0);
    @(negedge clk);
    check("b2b_old_hi_stall", stall, 1);
    check("b2b_old_hi", mdu_rd, mhi);
    cyc();
    drive(2'b10, FC_MULTU, 1'b1, 32'h0F0F_1234, 32'hFFFF_0001);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!stall) break;
      n++;
      cyc();
      @(negedge clk);
    end
    pop_model();
    check("b2b_stall_cycles", n, 31);
    check("b2b_idle_at_accept", busy, 0);
    exp_q.push_back(64'(32'h0F0F_1234) * 64'(32'hFFFF_0001));
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);
    mul_wait(n);
    check("b2b_second_busy_cycles", n, 32);
    cyc();
    drive(2'b10, FC_MFHI, 1'b1, '0, '0);
    @(negedge clk);
    check("b2b_final_hi", mdu_rd, mhi);
    cyc();
    drive(2'b10, FC_MFLO, 1'b1, '0, '0);
    @(negedge clk);
    check("b2b_final_lo", mdu_rd, mlo);
    cyc();
    drive(2'b00, 6'b0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
